fdiv_seq: RTL

Multi-cycle sequencer that computes a/b for single-precision operands as a * (1/b). It drives a shared combinational reciprocal datapath, then a shared multiplier datapath, one after the other.
Both datapaths are long combinational paths, so the block registers their operands and waits a parameterised number of cycles before sampling each result (multicycle-path constraint).
It sits between the FPU issue logic (valid/ready request) and the finv/fmul instances.

---
 rtl/fpu_pkg.sv | 32 +++
 rtl/fdiv_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: single-precision field layout, sequencer states and
// operand classification helpers.
package fpu_pkg;

   localparam int unsigned EXP_W = 8;
   localparam int unsigned MAN_W = 23;
   localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;

   localparam logic [EXP_W-1:0] EXP_ZERO = 8'h00;
   localparam logic [EXP_W-1:0] EXP_MAX  = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INV  = 2'd1,
      MUL  = 2'd2,
      DONE = 2'd3
   } fdiv_state_e;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   // Zero or subnormal: both are flushed to zero by the divide sequencer.
   function automatic logic exp_is_zero(input logic [FP_W-1:0] x);
      fp32_t f;
      f = fp32_t'(x);
      return f.exp == EXP_ZERO;
   endfunction

endpackage

// File: rtl/fdiv_seq.sv
// Divide sequencer: a/b = a * (1/b) using external finv and fmul datapaths,
// each treated as a multicycle path with registered operands.
module fdiv_seq
   import fpu_pkg::*;
#(
   parameter int unsigned INV_WAIT = 2,
   parameter int unsigned MUL_WAIT = 1,
   parameter int unsigned TAG_W    = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [FP_W-1:0]  in_a,
   input  logic [FP_W-1:0]  in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [FP_W-1:0]  out_d,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_dz,
   output logic             busy,
   output logic [FP_W-1:0]  finv_s,
   input  logic [FP_W-1:0]  finv_d,
   output logic [FP_W-1:0]  fmul_x1,
   output logic [FP_W-1:0]  fmul_x2,
   input  logic [FP_W-1:0]  fmul_y
);

   localparam int unsigned WAIT_MAX = (INV_WAIT > MUL_WAIT) ? INV_WAIT : MUL_WAIT;
   localparam int unsigned CNT_W    = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;

   fdiv_state_e      state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic [FP_W-1:0]  a_q,         a_d;
   logic [TAG_W-1:0] tag_q,       tag_d;
   logic [FP_W-1:0]  finv_s_q,    finv_s_d;
   logic [FP_W-1:0]  fmul_x1_q,   fmul_x1_d;
   logic [FP_W-1:0]  fmul_x2_q,   fmul_x2_d;
   logic             out_valid_q, out_valid_d;
   logic [FP_W-1:0]  out_d_q,     out_d_d;
   logic [TAG_W-1:0] out_tag_q,   out_tag_d;
   logic             out_dz_q,    out_dz_d;
   logic             accept;

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_d     = out_d_q;
   assign out_tag   = out_tag_q;
   assign out_dz    = out_dz_q;
   assign finv_s    = finv_s_q;
   assign fmul_x1   = fmul_x1_q;
   assign fmul_x2   = fmul_x2_q;

   // Next-state and datapath operand/result updates.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      tag_d       = tag_q;
      finv_s_d    = finv_s_q;
      fmul_x1_d   = fmul_x1_q;
      fmul_x2_d   = fmul_x2_q;
      out_valid_d = out_valid_q;
      out_d_d     = out_d_q;
      out_tag_d   = out_tag_q;
      out_dz_d    = out_dz_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               a_d   = in_a;
               tag_d = in_tag;
               // Divisor check wins over the dividend check.
               if (exp_is_zero(in_b)) begin
                  out_d_d     = {in_a[FP_W-1] ^ in_b[FP_W-1], EXP_MAX, MAN_W'(0)};
                  out_dz_d    = 1'b1;
                  out_tag_d   = in_tag;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else if (exp_is_zero(in_a)) begin
                  out_d_d     = {in_a[FP_W-1] ^ in_b[FP_W-1], (FP_W-1)'(0)};
                  out_dz_d    = 1'b0;
                  out_tag_d   = in_tag;
                  out_valid_d = 1'b1;
                  state_d     = DONE;
               end else begin
                  finv_s_d = in_b;
                  cnt_d    = CNT_W'(INV_WAIT - 1);
                  state_d  = INV;
               end
            end
         end
         INV: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               fmul_x1_d = a_q;
               fmul_x2_d = finv_d;
               cnt_d     = CNT_W'(MUL_WAIT - 1);
               state_d   = MUL;
            end
         end
         MUL: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               out_d_d     = fmul_y;
               out_dz_d    = 1'b0;
               out_tag_d   = tag_q;
               out_valid_d = 1'b1;
               state_d     = DONE;
            end
         end
         DONE: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         tag_q       <= '0;
         finv_s_q    <= '0;
         fmul_x1_q   <= '0;
         fmul_x2_q   <= '0;
         out_valid_q <= 1'b0;
         out_d_q     <= '0;
         out_tag_q   <= '0;
         out_dz_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         tag_q       <= tag_d;
         finv_s_q    <= finv_s_d;
         fmul_x1_q   <= fmul_x1_d;
         fmul_x2_q   <= fmul_x2_d;
         out_valid_q <= out_valid_d;
         out_d_q     <= out_d_d;
         out_tag_q   <= out_tag_d;
         out_dz_q    <= out_dz_d;
      end
   end

endmodule
